// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
//   Shared bus-map constants for the SPI/MCU bridge fabric.
//   - RAM_ADDR_WIDTH : address width of one space (RAM, CPU map, REG).
//   - WB_*_PREFIX    : upper address bits that steer the downstream decoder.
//   - WB_ADDR_WIDTH  : full Wishbone address width, prefix plus space address.
//   - space_e        : host command space encoding.
// -----------------------------------------------------------------------------
package common_pkg;

  localparam int unsigned RAM_ADDR_WIDTH  = 17;
  localparam int unsigned WB_PREFIX_WIDTH = 2;
  localparam int unsigned WB_ADDR_WIDTH   = WB_PREFIX_WIDTH + RAM_ADDR_WIDTH;

  localparam logic [WB_PREFIX_WIDTH-1:0] WB_RAM_PREFIX = 2'b00;
  localparam logic [WB_PREFIX_WIDTH-1:0] WB_CPU_PREFIX = 2'b01;
  localparam logic [WB_PREFIX_WIDTH-1:0] WB_REG_PREFIX = 2'b10;

  typedef enum logic [1:0] {
    SPACE_RAM     = 2'd0,
    SPACE_CPU     = 2'd1,
    SPACE_REG     = 2'd2,
    SPACE_INVALID = 2'd3
  } space_e;

  // Address prefix for a host space. The invalid space never reaches the bus,
  // so its mapping is irrelevant and shares the RAM prefix.
  function automatic logic [WB_PREFIX_WIDTH-1:0] space_prefix(input logic [1:0] space);
    logic [WB_PREFIX_WIDTH-1:0] prefix;
    prefix = WB_RAM_PREFIX;
    case (space)
      SPACE_CPU: prefix = WB_CPU_PREFIX;
      SPACE_REG: prefix = WB_REG_PREFIX;
      default:   prefix = WB_RAM_PREFIX;
    endcase
    return prefix;
  endfunction

endpackage : common_pkg

// File: rtl/wb_cmd_initiator.sv
// -----------------------------------------------------------------------------
// wb_cmd_initiator
//   Pipelined 8-bit Wishbone initiator. Each accepted host command becomes
//   exactly one bus cycle (or, for the invalid space, an immediate error
//   response), and each accepted command yields exactly one response.
//
// Ports
//   wb_clk_i / wb_rst_i   clock, asynchronous active-high reset
//   cmd_*                 host command (valid/ready handshake)
//   rsp_*                 host response (valid/ready handshake)
//   wb_cyc_o/wb_stb_o     Wishbone cycle / strobe
//   wb_we_o/wb_addr_o/
//   wb_dat_o              registered request fields, stable for the whole cycle
//   wb_dat_i              read data
//   wb_stall_i            target not accepting the strobe
//   wb_ack_i/wb_err_i     target completion / error completion
//
// Parameter
//   TIMEOUT_CYCLES        cycles from first strobe to ack/err before the cycle
//                         is aborted with an error (1..255)
// -----------------------------------------------------------------------------
module wb_cmd_initiator
  import common_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  // host command
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_space_i,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                      cmd_we_i,
  input  logic [7:0]                cmd_data_i,
  // host response
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [7:0]                rsp_data_o,
  output logic                      rsp_err_o,
  // wishbone
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]  wb_addr_o,
  output logic [7:0]                wb_dat_o,
  input  logic [7:0]                wb_dat_i,
  input  logic                      wb_stall_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RSP
  } state_e;

  // Timer value at which the cycle is abandoned: the timer is 0 in the first
  // strobe cycle, so this gives exactly TIMEOUT_CYCLES cycles with cyc high.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                   state_q,    state_d;
  logic [7:0]               timer_q,    timer_d;
  logic                     we_q,       we_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [7:0]               dat_q,      dat_d;
  logic [7:0]               rsp_data_q, rsp_data_d;
  logic                     rsp_err_q,  rsp_err_d;

  logic in_cycle;

  assign in_cycle = (state_q == S_REQ) || (state_q == S_WAIT);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_space_i == SPACE_INVALID) begin
            // Rejected without touching the bus.
            state_d    = S_RSP;
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            timer_d = 8'h00;
            we_d    = cmd_we_i;
            addr_d  = {space_prefix(cmd_space_i), cmd_addr_i};
            dat_d   = cmd_we_i ? cmd_data_i : 8'h00;
          end
        end
      end

      S_REQ, S_WAIT: begin
        timer_d = timer_q + 8'h01;
        // Priority: error, then ack, then timeout. An ack on the expiry cycle
        // therefore completes normally. Completion may coincide with strobe
        // acceptance, skipping WAIT entirely.
        if (wb_err_i) begin
          state_d    = S_RSP;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else if (wb_ack_i) begin
          state_d    = S_RSP;
          rsp_data_d = we_q ? 8'h00 : wb_dat_i;
          rsp_err_d  = 1'b0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d    = S_RSP;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
        end else if ((state_q == S_REQ) && !wb_stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_RSP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'h00;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from the state register so the async reset
  // clears cyc/stb/rsp_valid without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  assign wb_cyc_o  = in_cycle;
  assign wb_stb_o  = (state_q == S_REQ);
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;

endmodule : wb_cmd_initiator

// File: tb/tb_wb_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_initiator
//   Self-checking bench for wb_cmd_initiator (TIMEOUT_CYCLES = 16). Expected
//   responses are queued when a command is issued and compared when the DUT
//   presents its response. Inputs are driven and outputs sampled 1 ns after
//   the rising clock edge.
// -----------------------------------------------------------------------------
module tb_wb_cmd_initiator;
  import common_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      cmd_valid = 1'b0;
  logic                      cmd_ready;
  logic [1:0]                cmd_space = 2'd0;
  logic [RAM_ADDR_WIDTH-1:0] cmd_addr = '0;
  logic                      cmd_we = 1'b0;
  logic [7:0]                cmd_data = 8'h00;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [7:0]                rsp_data;
  logic                      rsp_err;
  logic                      wb_cyc, wb_stb, wb_we;
  logic [WB_ADDR_WIDTH-1:0]  wb_addr;
  logic [7:0]                wb_dat_o;
  logic [7:0]                wb_dat_i = 8'h00;
  logic                      wb_stall = 1'b0;
  logic                      wb_ack = 1'b0;
  logic                      wb_err = 1'b0;

  rsp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_space_i(cmd_space),
    .cmd_addr_i (cmd_addr),
    .cmd_we_i   (cmd_we),
    .cmd_data_i (cmd_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_addr_o  (wb_addr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_stall_i (wb_stall),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge and queue its expected response.
  // Returns 1 ns after the accepting edge.
  task automatic issue_cmd(input logic [1:0] space, input logic [RAM_ADDR_WIDTH-1:0] addr,
                           input logic we, input logic [7:0] data,
                           input logic [7:0] exp_data, input logic exp_err);
    rsp_t r;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    else pass_cnt++;
    cmd_valid = 1'b1;
    cmd_space = space;
    cmd_addr  = addr;
    cmd_we    = we;
    cmd_data  = data;
    r.data = exp_data;
    r.err  = exp_err;
    exp_q.push_back(r);
    tick();
    cmd_valid = 1'b0;
    cmd_space = 2'd0;
    cmd_addr  = '0;
    cmd_we    = 1'b0;
    cmd_data  = 8'h00;
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, consume it.
  task automatic collect_rsp(input string name);
    rsp_t r;
    int   budget;
    budget = 0;
    while (rsp_valid !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    total_cnt++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL %s_rsp_timeout: rsp_valid=%b after %0d cycles", name, rsp_valid, budget);
      return;
    end
    pass_cnt++;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s_unexpected_rsp: data=%h err=%b with empty scoreboard", name, rsp_data, rsp_err);
    end else begin
      r = exp_q.pop_front();
      total_cnt++;
      if (rsp_data !== r.data) $display("FAIL %s_data: got %h want %h", name, rsp_data, r.data);
      else pass_cnt++;
      total_cnt++;
      if (rsp_err !== r.err) $display("FAIL %s_err: got %b want %b", name, rsp_err, r.err);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL %s_release: rsp_valid=%b cmd_ready=%b want 0/1", name, rsp_valid, cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err, wb_we} !== 6'b100000)
      $display("FAIL reset_ctrl: ready/cyc/stb/rvalid/err/we=%b want 100000",
               {cmd_ready, wb_cyc, wb_stb, rsp_valid, rsp_err, wb_we});
    else pass_cnt++;
    total_cnt++;
    if (rsp_data !== 8'h00 || wb_addr !== '0 || wb_dat_o !== 8'h00)
      $display("FAIL reset_data: rsp_data=%h addr=%h dat=%h want 0", rsp_data, wb_addr, wb_dat_o);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    logic [WB_ADDR_WIDTH-1:0] exp_addr;
    exp_addr = {WB_CPU_PREFIX, 17'h08000};
    issue_cmd(2'd1, 17'h08000, 1'b0, 8'h00, 8'h5A, 1'b0);
    total_cnt++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b0 || wb_addr !== exp_addr)
      $display("FAIL cpu_read_req: cyc=%b stb=%b we=%b addr=%h want 1/1/0/%h",
               wb_cyc, wb_stb, wb_we, wb_addr, exp_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL cpu_read_wait: stb=%b cyc=%b rsp_valid=%b want 0/1/0", wb_stb, wb_cyc, rsp_valid);
    else pass_cnt++;
    wb_ack   = 1'b1;
    wb_dat_i = 8'h5A;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'h00;
    total_cnt++;
    if (rsp_valid !== 1'b1 || wb_cyc !== 1'b0)
      $display("FAIL cpu_read_latency: rsp_valid=%b cyc=%b want 1/0", rsp_valid, wb_cyc);
    else pass_cnt++;
    collect_rsp("cpu_read");
  endtask

  task automatic test_ram_write_stall();
    logic [WB_ADDR_WIDTH-1:0] exp_addr;
    exp_addr = {WB_RAM_PREFIX, 17'h1FFFF};
    wb_stall = 1'b1;
    issue_cmd(2'd0, 17'h1FFFF, 1'b1, 8'hA5, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (wb_stb !== 1'b1 || wb_we !== 1'b1 || wb_addr !== exp_addr || wb_dat_o !== 8'hA5)
        $display("FAIL ram_write_stb%0d: stb=%b we=%b addr=%h dat=%h want 1/1/%h/a5",
                 i, wb_stb, wb_we, wb_addr, wb_dat_o, exp_addr);
      else pass_cnt++;
      if (i == 3) wb_stall = 1'b0;
      tick();
    end
    total_cnt++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b1)
      $display("FAIL ram_write_wait: stb=%b cyc=%b want 0/1", wb_stb, wb_cyc);
    else pass_cnt++;
    wb_ack   = 1'b1;
    wb_dat_i = 8'hEE;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'h00;
    total_cnt++;
    if (wb_cyc !== 1'b0) $display("FAIL ram_write_cyc_drop: cyc=%b want 0", wb_cyc);
    else pass_cnt++;
    collect_rsp("ram_write");
  endtask

  task automatic test_reg_timeout();
    int cyc_cycles;
    issue_cmd(2'd2, 17'h00123, 1'b0, 8'h00, 8'h00, 1'b1);
    total_cnt++;
    if (wb_addr !== {WB_REG_PREFIX, 17'h00123})
      $display("FAIL reg_addr: got %h want %h", wb_addr, {WB_REG_PREFIX, 17'h00123});
    else pass_cnt++;
    cyc_cycles = 0;
    while (wb_cyc === 1'b1 && cyc_cycles < 40) begin
      cyc_cycles++;
      tick();
    end
    total_cnt++;
    if (cyc_cycles != TIMEOUT) $display("FAIL reg_timeout_len: cyc high %0d cycles want %0d", cyc_cycles, TIMEOUT);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b1) $display("FAIL reg_timeout_rsp: rsp_valid=%b want 1", rsp_valid);
    else pass_cnt++;
    collect_rsp("reg_timeout");
  endtask

  task automatic test_invalid_space();
    issue_cmd(2'd3, 17'h00042, 1'b1, 8'h11, 8'h00, 1'b1);
    total_cnt++;
    if (rsp_valid !== 1'b1 || wb_cyc !== 1'b0 || wb_stb !== 1'b0)
      $display("FAIL invalid_space: rsp_valid=%b cyc=%b stb=%b want 1/0/0", rsp_valid, wb_cyc, wb_stb);
    else pass_cnt++;
    collect_rsp("invalid_space");
  endtask

  task automatic test_write_err();
    issue_cmd(2'd0, 17'h00010, 1'b1, 8'h33, 8'h00, 1'b1);
    tick();
    wb_err = 1'b1;
    tick();
    wb_err = 1'b0;
    collect_rsp("write_err");
  endtask

  task automatic test_ack_with_accept();
    // Ack on the very edge that accepts the strobe.
    issue_cmd(2'd1, 17'h00077, 1'b0, 8'h00, 8'h77, 1'b0);
    wb_ack   = 1'b1;
    wb_dat_i = 8'h77;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'h00;
    total_cnt++;
    if (rsp_valid !== 1'b1 || wb_cyc !== 1'b0)
      $display("FAIL ack_with_accept: rsp_valid=%b cyc=%b want 1/0", rsp_valid, wb_cyc);
    else pass_cnt++;
    collect_rsp("ack_with_accept");
  endtask

  task automatic test_rsp_backpressure();
    int bad;
    issue_cmd(2'd1, 17'h00005, 1'b0, 8'h00, 8'h3C, 1'b0);
    tick();
    wb_ack   = 1'b1;
    wb_dat_i = 8'h3C;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'hC3;
    // A competing command is offered while the response waits.
    cmd_valid = 1'b1;
    cmd_space = 2'd0;
    cmd_addr  = 17'h00001;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || wb_cyc !== 1'b0)
        bad++;
      tick();
    end
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    wb_dat_i  = 8'h00;
    total_cnt++;
    if (bad != 0) $display("FAIL rsp_hold: %0d of 10 cycles unstable, want 0", bad);
    else pass_cnt++;
    collect_rsp("rsp_hold");
  endtask

  task automatic test_ack_err_both();
    issue_cmd(2'd2, 17'h00300, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    wb_ack   = 1'b1;
    wb_err   = 1'b1;
    wb_dat_i = 8'hFF;
    tick();
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = 8'h00;
    collect_rsp("ack_err_both");
  endtask

  task automatic test_reset_mid_wait();
    issue_cmd(2'd1, 17'h00200, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({wb_cyc, wb_stb, rsp_valid, cmd_ready} !== 4'b0001)
      $display("FAIL async_reset: cyc/stb/rvalid/ready=%b want 0001", {wb_cyc, wb_stb, rsp_valid, cmd_ready});
    else pass_cnt++;
    exp_q.delete();
    #1;
    rst = 1'b0;
    tick();
    wb_ack   = 1'b1;
    wb_dat_i = 8'h99;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'h00;
    total_cnt++;
    if ({wb_cyc, rsp_valid, cmd_ready} !== 3'b001)
      $display("FAIL stray_ack: cyc/rvalid/ready=%b want 001", {wb_cyc, rsp_valid, cmd_ready});
    else pass_cnt++;
    // Recovery: a normal read still works.
    issue_cmd(2'd0, 17'h00002, 1'b0, 8'h00, 8'h42, 1'b0);
    tick();
    wb_ack   = 1'b1;
    wb_dat_i = 8'h42;
    tick();
    wb_ack   = 1'b0;
    wb_dat_i = 8'h00;
    collect_rsp("after_reset");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ram_write_stall();
    test_reg_timeout();
    test_invalid_space();
    test_write_err();
    test_ack_with_accept();
    test_rsp_backpressure();
    test_ack_err_both();
    test_reset_mid_wait();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d responses missing, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_wb_cmd_initiator
